// File: rtl/ddr_sdram_refresh_scheduler.sv
// rtl/ddr_sdram_refresh_scheduler.sv - auto-refresh scheduler with postponement and user-refresh mode
module ddr_sdram_refresh_scheduler #(
  parameter int MEM_CHIPSELS = 1,
  parameter int TREFI_BITS   = 16,
  parameter int TRFC_BITS    = 7,
  parameter int MAX_POSTPONE = 8,
  parameter int PEND_BITS    = 4,
  parameter bit USER_REFRESH = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    init_done,
  input  logic [TREFI_BITS-1:0]   cfg_trefi,
  input  logic [TRFC_BITS-1:0]    cfg_trfc,
  input  logic                    ctrl_idle,
  input  logic                    refresh_grant,
  input  logic                    local_refresh_req,
  output logic                    refresh_req,
  output logic                    refresh_urgent,
  output logic [MEM_CHIPSELS-1:0] refresh_cs_n,
  output logic                    refresh_busy,
  output logic                    local_refresh_ack,
  output logic [PEND_BITS-1:0]    pending_count,
  output logic                    overflow_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RFC  = 2'd2
  } state_t;

  localparam logic [TREFI_BITS-1:0] TREFI_ONE   = TREFI_BITS'(1);
  localparam logic [TREFI_BITS-1:0] TREFI_MIN   = TREFI_BITS'(2);
  localparam logic [TRFC_BITS-1:0]  TRFC_ONE    = TRFC_BITS'(1);
  localparam logic [PEND_BITS-1:0]  PEND_ONE    = PEND_BITS'(1);
  localparam logic [PEND_BITS-1:0]  PEND_MAX    = PEND_BITS'(MAX_POSTPONE);
  localparam logic [PEND_BITS-1:0]  PEND_URGENT = PEND_BITS'(MAX_POSTPONE - 1);

  state_t                  state;
  logic [TREFI_BITS-1:0]   trefi_eff;
  logic [TREFI_BITS-1:0]   trefi_cnt;
  logic [TRFC_BITS-1:0]    trfc_eff;
  logic [TRFC_BITS-1:0]    trfc_cnt;
  logic                    tick;
  logic                    grant_hit;

  // Degenerate configurations are clamped so the timer and busy window never stall.
  assign trefi_eff = (cfg_trefi < TREFI_MIN) ? TREFI_MIN : cfg_trefi;
  assign trfc_eff  = (cfg_trfc == '0) ? TRFC_ONE : cfg_trfc;

  assign tick      = init_done & (USER_REFRESH ? local_refresh_req : (trefi_cnt == '0));
  assign grant_hit = refresh_grant & (state == REQ);

  assign refresh_urgent = (pending_count >= PEND_URGENT);

  always_ff @(posedge clk) begin
    if (!reset_n || !init_done || USER_REFRESH) begin
      trefi_cnt <= trefi_eff - TREFI_ONE;
    end else if (trefi_cnt == '0) begin
      trefi_cnt <= trefi_eff - TREFI_ONE;
    end else begin
      trefi_cnt <= trefi_cnt - TREFI_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= IDLE;
      pending_count     <= '0;
      trfc_cnt          <= '0;
      refresh_req       <= 1'b0;
      refresh_cs_n      <= '1;
      refresh_busy      <= 1'b0;
      local_refresh_ack <= 1'b0;
      overflow_err      <= 1'b0;
    end else if (!init_done) begin
      // overflow_err deliberately survives re-initialisation
      state             <= IDLE;
      pending_count     <= '0;
      trfc_cnt          <= '0;
      refresh_req       <= 1'b0;
      refresh_cs_n      <= '1;
      refresh_busy      <= 1'b0;
      local_refresh_ack <= 1'b0;
    end else begin
      local_refresh_ack <= 1'b0;

      if (tick && !grant_hit) begin
        if (pending_count == PEND_MAX) begin
          overflow_err <= 1'b1;
        end else begin
          pending_count <= pending_count + PEND_ONE;
        end
      end else if (grant_hit && !tick) begin
        pending_count <= pending_count - PEND_ONE;
      end

      case (state)
        IDLE: begin
          if ((pending_count != '0) && (ctrl_idle || refresh_urgent)) begin
            state        <= REQ;
            refresh_req  <= 1'b1;
            refresh_cs_n <= '0;
          end
        end
        REQ: begin
          if (refresh_grant) begin
            state             <= RFC;
            refresh_req       <= 1'b0;
            refresh_cs_n      <= '1;
            refresh_busy      <= 1'b1;
            local_refresh_ack <= 1'b1;
            trfc_cnt          <= trfc_eff - TRFC_ONE;
          end
        end
        RFC: begin
          if (trfc_cnt == '0) begin
            state        <= IDLE;
            refresh_busy <= 1'b0;
          end else begin
            trfc_cnt <= trfc_cnt - TRFC_ONE;
          end
        end
        default: begin
          state        <= IDLE;
          refresh_req  <= 1'b0;
          refresh_cs_n <= '1;
          refresh_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_sdram_refresh_scheduler.sv
// tb/tb_ddr_sdram_refresh_scheduler.sv - directed vector bench for the refresh scheduler
module tb_ddr_sdram_refresh_scheduler;

  localparam int CS = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          init_done;
  logic [15:0]   cfg_trefi;
  logic [6:0]    cfg_trfc;
  logic          ctrl_idle;
  logic          refresh_grant;
  logic          local_refresh_req;

  logic          d0_req, d0_urg, d0_busy, d0_ack, d0_ovf;
  logic [CS-1:0] d0_cs_n;
  logic [3:0]    d0_pend;
  logic          d1_req, d1_urg, d1_busy, d1_ack, d1_ovf;
  logic [CS-1:0] d1_cs_n;
  logic [3:0]    d1_pend;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int trefi;
    int trfc;
    int exp_first;
    int exp_busy;
    int exp_second;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  ddr_sdram_refresh_scheduler #(.MEM_CHIPSELS(CS), .USER_REFRESH(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .init_done(init_done),
    .cfg_trefi(cfg_trefi), .cfg_trfc(cfg_trfc), .ctrl_idle(ctrl_idle),
    .refresh_grant(refresh_grant), .local_refresh_req(local_refresh_req),
    .refresh_req(d0_req), .refresh_urgent(d0_urg), .refresh_cs_n(d0_cs_n),
    .refresh_busy(d0_busy), .local_refresh_ack(d0_ack),
    .pending_count(d0_pend), .overflow_err(d0_ovf)
  );

  ddr_sdram_refresh_scheduler #(.MEM_CHIPSELS(CS), .USER_REFRESH(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .init_done(init_done),
    .cfg_trefi(cfg_trefi), .cfg_trfc(cfg_trfc), .ctrl_idle(ctrl_idle),
    .refresh_grant(refresh_grant), .local_refresh_req(local_refresh_req),
    .refresh_req(d1_req), .refresh_urgent(d1_urg), .refresh_cs_n(d1_cs_n),
    .refresh_busy(d1_busy), .local_refresh_ack(d1_ack),
    .pending_count(d1_pend), .overflow_err(d1_ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic restart(input int trefi, input int trfc);
    reset_n           = 1'b0;
    init_done         = 1'b0;
    ctrl_idle         = 1'b0;
    refresh_grant     = 1'b0;
    local_refresh_req = 1'b0;
    cfg_trefi         = 16'(trefi);
    cfg_trfc          = 7'(trfc);
    step();
    reset_n = 1'b1;
    step();
    init_done = 1'b1;
    cyc = 0;
  endtask

  task automatic wait_req(input bit sel, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      if (sel ? d1_req : d0_req) ok = 1'b1;
      else step();
    end
    if (!ok && (sel ? d1_req : d0_req)) ok = 1'b1;
  endtask

  task automatic do_refresh(input bit sel, output int busy_len, output int acks);
    refresh_grant = 1'b1;
    step();
    refresh_grant = 1'b0;
    busy_len = 0;
    acks = 0;
    for (int k = 0; k < 300 && (sel ? d1_busy : d0_busy); k++) begin
      busy_len++;
      acks += int'(sel ? d1_ack : d0_ack);
      step();
    end
  endtask

  initial begin
    vec_t v;
    bit   ok;
    int   bl, ac, acks_total;

    vecs[0] = '{100, 7, 101, 7, 201};
    vecs[1] = '{2, 1, 3, 1, 0};
    vecs[2] = '{0, 0, 3, 1, 0};
    vecs[3] = '{1, 3, 3, 3, 0};
    vecs[4] = '{37, 127, 38, 127, 0};

    // reset state
    restart(100, 7);
    chk("rst_req", int'(d0_req), 0);
    chk("rst_urgent", int'(d0_urg), 0);
    chk("rst_cs_n", int'(d0_cs_n), 3);
    chk("rst_busy", int'(d0_busy), 0);
    chk("rst_ack", int'(d0_ack), 0);
    chk("rst_pending", int'(d0_pend), 0);
    chk("rst_ovf", int'(d0_ovf), 0);
    chk("rst_cs_n_user", int'(d1_cs_n), 3);

    // timer vectors, including clamped intervals
    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      restart(v.trefi, v.trfc);
      ctrl_idle = 1'b1;
      wait_req(1'b0, 400, ok);
      chk("first_req_seen", int'(ok), 1);
      chk("first_req_cycle", cyc, v.exp_first);
      chk("req_cs_n", int'(d0_cs_n), 0);
      do_refresh(1'b0, bl, ac);
      chk("busy_len", bl, v.exp_busy);
      chk("ack_pulses", ac, 1);
      if (v.exp_second != 0) begin
        chk("pending_zero", int'(d0_pend), 0);
        wait_req(1'b0, 200, ok);
        chk("second_req_cycle", cyc, v.exp_second);
      end
    end

    // postponement up to saturation and overflow
    restart(10, 3);
    for (int k = 1; k <= 8; k++) begin
      repeat (10) step();
      chk("postpone_pending", int'(d0_pend), k);
      chk("postpone_urgent", int'(d0_urg), (k >= 7) ? 1 : 0);
    end
    chk("urgent_req", int'(d0_req), 1);
    chk("urgent_cs_n", int'(d0_cs_n), 0);
    chk("ovf_before", int'(d0_ovf), 0);
    cfg_trefi = 16'd1000;
    repeat (10) step();
    chk("sat_pending", int'(d0_pend), 8);
    chk("ovf_set", int'(d0_ovf), 1);

    // drain eight refreshes
    ctrl_idle = 1'b1;
    acks_total = 0;
    for (int r = 0; r < 8; r++) begin
      wait_req(1'b0, 30, ok);
      chk("drain_req", int'(ok), 1);
      do_refresh(1'b0, bl, ac);
      chk("drain_busy", bl, 3);
      acks_total += ac;
    end
    chk("drain_acks", acks_total, 8);
    chk("drain_pending", int'(d0_pend), 0);
    chk("drain_ovf", int'(d0_ovf), 1);
    repeat (5) step();
    chk("drain_no_req", int'(d0_req), 0);

    // init_done low retains overflow, then reset in the 3rd busy cycle
    init_done = 1'b0;
    cfg_trefi = 16'd10;
    cfg_trfc  = 7'd7;
    repeat (3) step();
    chk("init_ovf_kept", int'(d0_ovf), 1);
    chk("init_pending", int'(d0_pend), 0);
    init_done = 1'b1;
    cyc = 0;
    wait_req(1'b0, 40, ok);
    chk("reinit_req_cycle", cyc, 11);
    refresh_grant = 1'b1;
    step();
    refresh_grant = 1'b0;
    chk("rfc_ack", int'(d0_ack), 1);
    step();
    step();
    chk("rfc_busy3", int'(d0_busy), 1);
    reset_n = 1'b0;
    step();
    chk("mid_rst_busy", int'(d0_busy), 0);
    chk("mid_rst_pending", int'(d0_pend), 0);
    chk("mid_rst_cs_n", int'(d0_cs_n), 3);
    chk("mid_rst_ovf", int'(d0_ovf), 0);
    chk("mid_rst_req", int'(d0_req), 0);
    reset_n = 1'b1;
    refresh_grant = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("spurious_ack", int'(d0_ack), 0);
      chk("spurious_pending", int'(d0_pend), 0);
      chk("spurious_busy", int'(d0_busy), 0);
    end
    refresh_grant = 1'b0;

    // tick coincident with grant at pending 3
    restart(10, 7);
    repeat (30) step();
    chk("sim_pending_pre", int'(d0_pend), 3);
    ctrl_idle = 1'b1;
    repeat (9) step();
    chk("sim_req", int'(d0_req), 1);
    chk("sim_pending_req", int'(d0_pend), 3);
    refresh_grant = 1'b1;
    step();
    refresh_grant = 1'b0;
    chk("sim_pending_post", int'(d0_pend), 3);
    chk("sim_ack", int'(d0_ack), 1);
    chk("sim_busy", int'(d0_busy), 1);
    step();
    chk("sim_ack_single", int'(d0_ack), 0);
    chk("sim_busy2", int'(d0_busy), 1);

    // user-refresh mode
    restart(10, 4);
    for (int p = 0; p < 3; p++) begin
      local_refresh_req = 1'b1;
      step();
      local_refresh_req = 1'b0;
      repeat (3) step();
    end
    repeat (30) step();
    chk("user_pending", int'(d1_pend), 3);
    chk("user_no_req", int'(d1_req), 0);
    ctrl_idle = 1'b1;
    acks_total = 0;
    for (int r = 0; r < 3; r++) begin
      wait_req(1'b1, 30, ok);
      chk("user_req", int'(ok), 1);
      do_refresh(1'b1, bl, ac);
      chk("user_busy", bl, 4);
      acks_total += ac;
    end
    chk("user_acks", acks_total, 3);
    chk("user_pending_end", int'(d1_pend), 0);
    repeat (20) step();
    chk("user_no_timer", int'(d1_pend), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_sdram_refresh_scheduler.md
Name: ddr_sdram_refresh_scheduler

Overview:
- Parametrised auto-refresh scheduler for the DDR SDRAM high-performance controller family.
- Replaces the hard-wired single-rank tREFI/tRFC constants with run-time configurable timing, multi-rank chip-select support, refresh postponement and an optional user-refresh mode.
- Sits between the controller's timing-parameter block and its command sequencer, which arbitrates refresh against read/write traffic.

Parameters:
- MEM_CHIPSELS, 1, number of ranks; all ranks refresh together.
- TREFI_BITS, 16, width of the tREFI interval counter.
- TRFC_BITS, 7, width of the tRFC busy counter.
- MAX_POSTPONE, 8, maximum outstanding refreshes (2..15).
- PEND_BITS, 4, width of the pending counter; must satisfy 2^PEND_BITS > MAX_POSTPONE.
- USER_REFRESH, 0, selects refresh source: 0 = internal tREFI timer, 1 = local_refresh_req only.

Ports:
- clk  in  1  controller clock.
- reset_n  in  1  synchronous, active-low reset.
- init_done  in  1  memory initialisation complete.
- cfg_trefi  in  TREFI_BITS  refresh interval in clk cycles.
- cfg_trfc  in  TRFC_BITS  refresh-to-command time in clk cycles.
- ctrl_idle  in  1  sequencer has no queued command and all banks are precharged.
- refresh_grant  in  1  one-cycle pulse: sequencer issued the REFRESH command.
- local_refresh_req  in  1  user refresh request pulse (used only when USER_REFRESH=1).
- refresh_req  out  1  refresh wanted; held until granted.
- refresh_urgent  out  1  postponement limit reached; sequencer must drain and grant.
- refresh_cs_n  out  MEM_CHIPSELS  chip selects for the REFRESH command.
- refresh_busy  out  1  tRFC window active; no commands allowed.
- local_refresh_ack  out  1  one-cycle pulse on grant.
- pending_count  out  PEND_BITS  outstanding refreshes.
- overflow_err  out  1  sticky flag: a refresh was lost.

Behaviour:
- Reset: reset_n sampled low at a clk edge returns the block to its reset state, including mid-operation.
  - All outputs 0 except refresh_cs_n, which is all ones.
  - FSM goes to IDLE, pending = 0, tREFI counter loads to the effective interval.
- Effective interval: trefi_eff = max(cfg_trefi, 2). Effective busy time: trfc_eff = max(cfg_trfc, 1).
- While init_done = 0:
  - tREFI counter is held at trefi_eff-1.
  - pending is held at 0 and the FSM is forced to IDLE.
  - overflow_err is retained.
- Timer (USER_REFRESH=0, init_done=1):
  - Down-counter runs from trefi_eff-1 to 0.
  - At 0 it generates a one-cycle tick and reloads on the following cycle.
  - First tick occurs trefi_eff cycles after init_done rises.
  - cfg_trefi changes take effect at the next reload.
- User mode (USER_REFRESH=1): the timer is disabled; each local_refresh_req cycle acts as a tick.
- Pending counter:
  - Increments by 1 on tick; decrements by 1 on refresh_grant while in REQ.
  - Tick and grant in the same cycle leave it unchanged.
  - Tick with pending = MAX_POSTPONE (and no grant): pending stays at MAX_POSTPONE and overflow_err sets; it clears only on reset.
- refresh_urgent = (pending >= MAX_POSTPONE-1), combinational from the registered pending value.
- FSM:
  - IDLE:
    - Go to REQ when pending > 0 and (ctrl_idle or refresh_urgent).
    - refresh_req = 0; refresh_cs_n = all ones.
  - REQ:
    - refresh_req = 1 and refresh_cs_n = all zeros, driven from the cycle after entry until grant.
    - On refresh_grant: local_refresh_ack = 1 in the next cycle, tRFC counter loads trfc_eff-1, go to RFC.
    - ctrl_idle falling does not withdraw the request.
  - RFC:
    - refresh_busy = 1 for exactly trfc_eff cycles, starting the cycle after grant.
    - refresh_req = 0 throughout.
    - At counter 0, go to IDLE.
    - Ticks during RFC still accumulate in pending.
- Back-to-back: with pending > 0 after RFC and ctrl_idle = 1, REQ re-asserts one cycle after refresh_busy falls.
- refresh_grant outside REQ is ignored: no pending change, no ack.
- All outputs are registered, except refresh_urgent.

Test Plan:
- Basic timer: USER_REFRESH=0, cfg_trefi=100, cfg_trfc=7, ctrl_idle=1, init_done rises at cycle 0, grant one cycle after each refresh_req.
  - refresh_req rises at cycle 101.
  - local_refresh_ack is a single pulse.
  - refresh_busy is high for exactly 7 cycles.
  - pending returns to 0.
  - Ticks repeat every 100 cycles.
- Postponement: cfg_trefi=10, ctrl_idle=0, no grant.
  - pending rises 1..7; refresh_urgent asserts at pending=7.
  - pending saturates at 8; the next tick sets overflow_err; pending stays 8.
- Drain: from pending=8, raise ctrl_idle and grant every REQ.
  - Eight refreshes occur, each separated by the tRFC busy window.
  - pending reaches 0; overflow_err remains 1.
- Simultaneous events: align a timer tick with refresh_grant at pending=3.
  - pending stays 3.
  - One ack pulse; FSM enters RFC.
- User mode: USER_REFRESH=1, three local_refresh_req pulses with no timer ticks.
  - pending=3.
  - Three grants produce three local_refresh_ack pulses.
  - Timer never ticks.
- Reset mid-RFC: assert reset_n=0 for one cycle in the 3rd busy cycle.
  - Next cycle: refresh_busy=0, pending=0, refresh_cs_n=1, overflow_err=0, state IDLE.
  - Spurious grants are ignored.
